// File: rtl/tft_if.sv
// TFT timing bundle: control pulses in, raster and line-buffer strobes out.
interface tft_if;
  logic       tft_on_reg;
  logic       line_done;
  logic       clr_underrun;
  logic       HSYNC_n;
  logic       VSYNC_n;
  logic       DE;
  logic       BRAM_TFT_rd;
  logic       BRAM_TFT_oe;
  logic       get_line;
  logic [8:0] line_num;
  logic       frame_start;
  logic       underrun;
  logic       underrun_irq;

  modport master (
    output tft_on_reg, line_done, clr_underrun,
    input  HSYNC_n, VSYNC_n, DE, BRAM_TFT_rd, BRAM_TFT_oe,
    input  get_line, line_num, frame_start, underrun, underrun_irq
  );

  modport slave (
    input  tft_on_reg, line_done, clr_underrun,
    output HSYNC_n, VSYNC_n, DE, BRAM_TFT_rd, BRAM_TFT_oe,
    output get_line, line_num, frame_start, underrun, underrun_irq
  );
endinterface

// File: rtl/tft_timing_gen.sv
// Raster timing generator for the TFT panel with line-buffer read strobes,
// per-line fetch requests and underrun detection.
module tft_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10
) (
  input  logic   tft_clk,
  input  logic   tft_rst,
  tft_if.slave   bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HA      = H_SYNC + H_BP;
  localparam int unsigned VA      = V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_RD_FIRST  = 10'(HA - 2);
  localparam logic [9:0] H_RD_LAST   = 10'(HA + H_ACTIVE - 3);
  localparam logic [9:0] H_OE_FIRST  = 10'(HA - 1);
  localparam logic [9:0] H_OE_LAST   = 10'(HA + H_ACTIVE - 2);
  localparam logic [9:0] H_DE_FIRST  = 10'(HA);
  localparam logic [9:0] H_DE_LAST   = 10'(HA + H_ACTIVE - 1);
  localparam logic [9:0] H_GET       = 10'(HA + H_ACTIVE);
  localparam logic [9:0] V_ACT_FIRST = 10'(VA);
  localparam logic [9:0] V_ACT_LAST  = 10'(VA + V_ACTIVE - 1);
  localparam logic [9:0] V_REQ_FIRST = 10'(VA - 1);
  localparam logic [9:0] V_REQ_LAST  = 10'(VA + V_ACTIVE - 2);

  // Counters hold the position whose outputs are being computed, so every
  // output flop presents that position one cycle later.
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       en_frame_q, en_frame_d;
  logic       pending_q, pending_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       de_q, de_d;
  logic       rd_q, rd_d;
  logic       oe_q, oe_d;
  logic       get_line_q, get_line_d;
  logic [8:0] line_num_q, line_num_d;
  logic       frame_start_q, frame_start_d;
  logic       underrun_q, underrun_d;
  logic       irq_q, irq_d;

  logic h_wrap, frame_pos, line_en, check, pend_now, evt;

  always_ff @(posedge tft_clk) begin
    if (tft_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      en_frame_q    <= 1'b0;
      pending_q     <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      de_q          <= 1'b0;
      rd_q          <= 1'b0;
      oe_q          <= 1'b0;
      get_line_q    <= 1'b0;
      line_num_q    <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      en_frame_q    <= en_frame_d;
      pending_q     <= pending_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      de_q          <= de_d;
      rd_q          <= rd_d;
      oe_q          <= oe_d;
      get_line_q    <= get_line_d;
      line_num_q    <= line_num_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      irq_q         <= irq_d;
    end
  end

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end

    frame_pos     = (h_cnt_q == '0) && (v_cnt_q == '0);
    en_frame_d    = frame_pos ? bus.tft_on_reg : en_frame_q;
    frame_start_d = frame_pos;
    line_en       = en_frame_d && (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST);

    hsync_n_d = (h_cnt_q >= H_SYNC_END);
    vsync_n_d = (v_cnt_q >= V_SYNC_END);
    rd_d      = line_en && (h_cnt_q >= H_RD_FIRST) && (h_cnt_q <= H_RD_LAST);
    oe_d      = line_en && (h_cnt_q >= H_OE_FIRST) && (h_cnt_q <= H_OE_LAST);
    de_d      = line_en && (h_cnt_q >= H_DE_FIRST) && (h_cnt_q <= H_DE_LAST);

    get_line_d = en_frame_d && (h_cnt_q == H_GET) &&
                 (v_cnt_q >= V_REQ_FIRST) && (v_cnt_q <= V_REQ_LAST);
    line_num_d = get_line_d ? 9'(v_cnt_q - V_REQ_FIRST) : line_num_q;

    // A done pulse seen alongside a fresh request belongs to the previous one.
    pend_now  = get_line_q | (pending_q & ~bus.line_done);
    check     = line_en && (h_cnt_q == H_RD_FIRST);
    evt       = check && pend_now;
    pending_d = check ? 1'b0 : pend_now;

    underrun_d = evt | (underrun_q & ~bus.clr_underrun);
    irq_d      = evt & (~underrun_q | bus.clr_underrun);
  end

  assign bus.HSYNC_n      = hsync_n_q;
  assign bus.VSYNC_n      = vsync_n_q;
  assign bus.DE           = de_q;
  assign bus.BRAM_TFT_rd  = rd_q;
  assign bus.BRAM_TFT_oe  = oe_q;
  assign bus.get_line     = get_line_q;
  assign bus.line_num     = line_num_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_irq = irq_q;

endmodule

// File: doc/tft_timing_gen.md
Name: tft_timing_gen

Overview:
- Generates 640x480@60 raster timing on the TFT clock domain: HSYNC, VSYNC and DE.
- Drives the read side of the RGB line buffer: BRAM_TFT_rd two cycles before DE, BRAM_TFT_oe one cycle before DE.
- Issues a per-line fetch request with the line number to the PLB-side line-fill logic.
- Checks that each line was filled before its readout starts, and flags underruns.

Parameters:
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch

Ports:
- tft_clk  in  1  pixel clock; all logic on its rising edge
- tft_rst  in  1  synchronous reset, active-high
- tft_on_reg  in  1  display enable from control register
- line_done  in  1  one-cycle pulse from the PLB side: requested line fully written
- clr_underrun  in  1  one-cycle pulse: clears underrun
- HSYNC_n  out  1  horizontal sync, active-low
- VSYNC_n  out  1  vertical sync, active-low
- DE  out  1  data enable
- BRAM_TFT_rd  out  1  line-buffer read enable
- BRAM_TFT_oe  out  1  line-buffer output-register enable
- get_line  out  1  one-cycle fetch request
- line_num  out  9  active-line index for the fetch (0..V_ACTIVE-1)
- frame_start  out  1  one-cycle pulse at the start of each frame
- underrun  out  1  sticky underrun flag
- underrun_irq  out  1  one-cycle pulse when underrun is set

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525).
  - HA = H_SYNC+H_BP (144); VA = V_SYNC+V_BP (35).
  - h_pos and v_pos are 10-bit counters; H_TOTAL and V_TOTAL must each be at most 1024.
- Reset (while tft_rst high):
  - h_pos=0, v_pos=0.
  - HSYNC_n=1, VSYNC_n=1; all other outputs 0; line_num=0.
  - Internal state: en_frame=0, pending=0.
  - In the first cycle after release, h_pos=0 and v_pos=0.
- Counters:
  - h_pos increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_pos increments on that wrap and wraps V_TOTAL-1 -> 0.
- Output timing: all outputs are registered and glitch-free. Values below are those presented in the cycle whose position is (h_pos, v_pos).
  - HSYNC_n=0 for h_pos 0..H_SYNC-1 (every line).
  - VSYNC_n=0 for v_pos 0..V_SYNC-1 (whole lines).
  - Active line: v_pos in VA..VA+V_ACTIVE-1.
  - On active lines with en_frame=1:
    - BRAM_TFT_rd=1 for h_pos HA-2..HA+H_ACTIVE-3.
    - BRAM_TFT_oe=1 for h_pos HA-1..HA+H_ACTIVE-2.
    - DE=1 for h_pos HA..HA+H_ACTIVE-1.
  - Each of these windows is exactly H_ACTIVE cycles.
- Enable:
  - en_frame samples tft_on_reg only at h_pos=0, v_pos=0. A change mid-frame takes effect at the next frame.
  - When en_frame=0, DE/rd/oe stay 0 while the syncs keep running.
- frame_start: 1 at h_pos=0, v_pos=0, regardless of en_frame.
- Fetch request:
  - get_line=1 at h_pos=HA+H_ACTIVE (784) when v_pos+1 is an active line, i.e. v_pos in VA-1..VA+V_ACTIVE-2.
  - Requires en_frame=1.
  - line_num updates in the same cycle to v_pos+1-VA and holds until the next get_line.
  - Sequence per frame: 0..V_ACTIVE-1, exactly V_ACTIVE requests.
- Handshake and underrun:
  - get_line sets pending; line_done clears it.
  - If get_line and line_done coincide, pending=1 (the done belongs to the previous request).
  - line_done while pending=0 is ignored.
  - At the first rd cycle of an active line (h_pos=HA-2), pending=1 means underrun:
    - underrun goes to 1; underrun_irq pulses for 1 cycle, only if underrun was previously 0.
    - pending is cleared.
  - clr_underrun clears underrun. If the clear coincides with a new underrun event, set wins and the irq pulses.
  - underrun does not alter the timing outputs.
- Reset mid-frame: everything returns to reset values on the next edge, and timing restarts from h_pos=0, v_pos=0.

Test Plan:
- Reset:
  - Stimulus: assert tft_rst 5 cycles with tft_on_reg=1.
  - Response: HSYNC_n=VSYNC_n=1, all other outputs 0.
  - After release: frame_start in the first cycle; HSYNC_n low for exactly 96 cycles; period 800 cycles.
- Read-window alignment:
  - Stimulus: tft_on_reg=1, line_done returned 10 cycles after each get_line; observe line v_pos=35.
  - Response: rd rises at h_pos 142, oe at 143, DE at 144; each is high exactly 640 cycles; DE falls after h_pos 783.
- Frame structure:
  - Stimulus: run 2 full frames.
  - Response: VSYNC_n low for 2 lines (1600 cycles); frame period 420000 cycles; 480 DE lines per frame starting at v_pos 35.
- Fetch sequence:
  - Stimulus: run one frame.
  - Response: exactly 480 get_line pulses, each at h_pos 784; the first at v_pos 34 with line_num=0, the last at v_pos 513 with line_num=479; no underrun.
- Enable switching:
  - Stimulus: drop tft_on_reg at v_pos 200.
  - Response: DE/rd/oe continue to the end of that frame, are 0 in the next frame, get_line stops, syncs continue.
  - Stimulus: re-raise tft_on_reg.
  - Response: resumes at the following frame boundary.
- Underrun:
  - Stimulus: withhold line_done for the request with line_num=5.
  - Response: at h_pos 142 of v_pos 40, underrun goes to 1 with a 1-cycle underrun_irq.
  - Stimulus: a second miss while underrun is still set.
  - Response: no further irq.
  - Stimulus: clr_underrun.
  - Response: underrun goes to 0.
  - Stimulus: get_line and line_done in the same cycle.
  - Response: pending=1.
